// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size and fault encodings,
// bank ids, FSM states, default segment map and lane helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [1:0] CODE_OK         = 2'b00;
    localparam logic [1:0] CODE_UNMAPPED   = 2'b01;
    localparam logic [1:0] CODE_MISALIGNED = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL    = 2'b11;

    localparam logic [1:0] BANK_DATA  = 2'd0;
    localparam logic [1:0] BANK_STACK = 2'd1;
    localparam logic [1:0] BANK_MMIO  = 2'd2;

    localparam logic [31:0] DEF_DATA_BASE  = 32'h1001_0000;
    localparam logic [31:0] DEF_STACK_BASE = 32'hEFFF_F000;
    localparam logic [31:0] DEF_MMIO_BASE  = 32'hFFFF_0000;
    localparam int          DEF_SEG_BYTES  = 4096;
    localparam int          DEF_MMIO_BYTES = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } state_t;

    // Pull the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] extractLane(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sgn);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: return {{24{sgn & b[7]}}, b};
            SIZE_HALF: return {{16{sgn & h[15]}}, h};
            default:   return word;
        endcase
    endfunction

    // Replace the addressed lane of a RAM word with right-aligned store data.
    function automatic logic [31:0] mergeLane(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
        logic [31:0] mask;
        mask = 32'h0000_00FF << {off, 3'b000};
        case (size)
            SIZE_BYTE: return (word & ~mask) | ((data & 32'h0000_00FF) << {off, 3'b000});
            SIZE_HALF: return off[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decoder: virtual byte address + access size to
// bank, word address and fault code (illegal size > unmapped > misaligned).
module mem_region_decode
    import mem_pkg::*;
#(
    parameter int          ADDR_W     = 11,
    parameter logic [31:0] DATA_BASE  = DEF_DATA_BASE,
    parameter logic [31:0] STACK_BASE = DEF_STACK_BASE,
    parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
    parameter int          SEG_BYTES  = DEF_SEG_BYTES,
    parameter int          MMIO_BYTES = DEF_MMIO_BYTES
) (
    input  logic [31:0]       va,
    input  logic [1:0]        size,
    output logic              hit,
    output logic [1:0]        bank,
    output logic [ADDR_W-1:0] wordAddr,
    output logic              fault,
    output logic [1:0]        code
);

    localparam logic [31:0] DATA_LAST  = DATA_BASE  + 32'(SEG_BYTES)  - 32'd1;
    localparam logic [31:0] STACK_LAST = STACK_BASE + 32'(SEG_BYTES)  - 32'd1;
    localparam logic [31:0] MMIO_LAST  = MMIO_BASE  + 32'(MMIO_BYTES) - 32'd1;

    logic [31:0] offset;
    logic        misaligned;

    // Region match, word address and prioritised fault code.
    always_comb begin
        hit    = 1'b0;
        bank   = BANK_DATA;
        offset = 32'd0;
        if (va >= DATA_BASE && va <= DATA_LAST) begin
            hit    = 1'b1;
            bank   = BANK_DATA;
            offset = va - DATA_BASE;
        end else if (va >= STACK_BASE && va <= STACK_LAST) begin
            hit    = 1'b1;
            bank   = BANK_STACK;
            offset = va - STACK_BASE;
        end else if (va >= MMIO_BASE && va <= MMIO_LAST) begin
            hit    = 1'b1;
            bank   = BANK_MMIO;
            offset = va - MMIO_BASE;
        end
        wordAddr = ADDR_W'(offset >> 2);

        // Device registers are word-only, so sub-word MMIO counts as misaligned.
        misaligned = ((size == SIZE_HALF) && va[0])
                  || ((size == SIZE_WORD) && (va[1:0] != 2'b00))
                  || ((bank == BANK_MMIO) && (size != SIZE_WORD));

        if (size == SIZE_ILLEGAL)  code = CODE_ILLEGAL;
        else if (!hit)             code = CODE_UNMAPPED;
        else if (misaligned)       code = CODE_MISALIGNED;
        else                       code = CODE_OK;
        fault = (code != CODE_OK);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU and the banked word RAMs: decodes the
// request, runs read / read-modify-write / write sequences and returns a
// one-cycle response carrying extended load data or a fault code.
//
// Request handshake: a request transfers on a rising edge where req_valid
// and req_ready are both 1. req_ready is high only in IDLE, and all request
// inputs are ignored while it is low. The response is a single-cycle
// resp_valid pulse with no backpressure.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int          ADDR_W     = 11,
    parameter logic [31:0] DATA_BASE  = DEF_DATA_BASE,
    parameter logic [31:0] STACK_BASE = DEF_STACK_BASE,
    parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
    parameter int          SEG_BYTES  = DEF_SEG_BYTES,
    parameter int          MMIO_BYTES = DEF_MMIO_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_code,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_bank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output state_t            dbgState
);

    state_t            state, nextState;
    logic              decHit, decFault;
    logic [1:0]        decBank, decCode;
    logic [ADDR_W-1:0] decWordAddr;

    logic              rWrite, rSigned;
    logic [1:0]        rSize, rOff, rCode;
    logic [31:0]       rdataQ, wdataQ;

    mem_region_decode #(
        .ADDR_W    (ADDR_W),
        .DATA_BASE (DATA_BASE),
        .STACK_BASE(STACK_BASE),
        .MMIO_BASE (MMIO_BASE),
        .SEG_BYTES (SEG_BYTES),
        .MMIO_BYTES(MMIO_BYTES)
    ) u_decode (
        .va      (req_addr),
        .size    (req_size),
        .hit     (decHit),
        .bank    (decBank),
        .wordAddr(decWordAddr),
        .fault   (decFault),
        .code    (decCode)
    );

    // State register; reset abandons any sequence in flight, including a pending RMW write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nextState;
    end

    // Next state and the state-decoded strobes.
    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (decFault)                               nextState = ST_RESP;
                    else if (req_write && req_size == SIZE_WORD) nextState = ST_WR;
                    else                                        nextState = ST_RD;
                end
            end
            ST_RD: begin
                mem_en    = 1'b1;
                nextState = ST_RD_WAIT;
            end
            ST_RD_WAIT: nextState = rWrite ? ST_WR : ST_RESP;
            ST_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                nextState = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                nextState  = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
        resp_err = resp_valid && (rCode != CODE_OK);
    end

    // Request capture on accept, then lane extract (load) or lane merge (sub-word store).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rWrite   <= 1'b0;
            rSigned  <= 1'b0;
            rSize    <= SIZE_BYTE;
            rOff     <= 2'b00;
            rCode    <= CODE_OK;
            mem_bank <= BANK_DATA;
            mem_addr <= '0;
            wdataQ   <= 32'd0;
            rdataQ   <= 32'd0;
        end else if (state == ST_IDLE && req_valid) begin
            rWrite   <= req_write;
            rSigned  <= req_signed;
            rSize    <= req_size;
            rOff     <= req_addr[1:0];
            rCode    <= decCode;
            mem_bank <= decHit ? decBank : BANK_DATA;
            mem_addr <= decWordAddr;
            wdataQ   <= req_wdata;
            rdataQ   <= 32'd0;
        end else if (state == ST_RD_WAIT) begin
            if (rWrite) wdataQ <= mergeLane(mem_rdata, wdataQ, rSize, rOff);
            else        rdataQ <= extractLane(mem_rdata, rSize, rOff, rSigned);
        end
    end

    assign resp_rdata = rdataQ;
    assign resp_code  = rCode;
    assign mem_wdata  = wdataQ;
    assign dbgState   = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by randomized
// requests, each compared against a behavioural model of the address map
// and byte lanes working on a reference copy of the RAM.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int ADDR_W = 11;
    localparam longint M_DATA_BASE  = 64'h1001_0000;
    localparam longint M_STACK_BASE = 64'hEFFF_F000;
    localparam longint M_MMIO_BASE  = 64'hFFFF_0000;
    localparam longint M_SEG        = 4096;
    localparam longint M_MMIO       = 64;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              req_valid, req_ready, req_write, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_code;
    logic              mem_en, mem_we;
    logic [1:0]        mem_bank;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    state_t            dbgState;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_code(resp_code), .mem_en(mem_en), .mem_we(mem_we),
        .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbgState(dbgState)
    );

    // RAM model driven by the DUT plus a poke port for the stimulus side.
    logic [31:0] ram    [0:2][0:2047] = '{default: 32'h0};
    logic [31:0] refMem [0:2][0:2047] = '{default: 32'h0};
    logic        pokeEn = 1'b0;
    int          pokeBank, pokeIdx;
    logic [31:0] pokeVal;
    int          enCount = 0, weCount = 0;
    logic [1:0]  lastBank = 2'd0;
    logic [ADDR_W-1:0] lastAddr = '0;

    always @(posedge clk) begin
        if (pokeEn) ram[pokeBank][pokeIdx] <= pokeVal;
        if (mem_en) begin
            enCount  <= enCount + 1;
            lastBank <= mem_bank;
            lastAddr <= mem_addr;
            if (mem_we) begin
                weCount <= weCount + 1;
                ram[mem_bank][mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_bank][mem_addr];
            end
        end
    end

    // scoreboard counters and checker
    int passCount = 0, checkCount = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else passCount++;
    endtask

    // Address map at byte level.
    function automatic bit regionOf(input logic [31:0] va, output int bank, output int idx);
        longint a;
        a = longint'(va);
        bank = 0; idx = 0;
        if (a >= M_DATA_BASE && a < M_DATA_BASE + M_SEG) begin
            bank = 0; idx = int'((a - M_DATA_BASE) / 4); return 1'b1;
        end
        if (a >= M_STACK_BASE && a < M_STACK_BASE + M_SEG) begin
            bank = 1; idx = int'((a - M_STACK_BASE) / 4); return 1'b1;
        end
        if (a >= M_MMIO_BASE && a < M_MMIO_BASE + M_MMIO) begin
            bank = 2; idx = int'((a - M_MMIO_BASE) / 4); return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference behaviour of one request against refMem.
    function automatic void model(input logic write, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] va, input logic [31:0] wd,
                                  output logic [1:0] code, output int bank, output int idx,
                                  output logic [31:0] rdata, output logic [31:0] newWord,
                                  output int lat, output int ens, output int wes);
        int nbytes, lane;
        logic [31:0] mask, old, val;
        bit hit;
        nbytes = 1 << size;
        hit = regionOf(va, bank, idx);
        rdata = 32'h0; newWord = 32'h0;
        if (size == 2'b11)                                      code = 2'b11;
        else if (!hit)                                          code = 2'b01;
        else if ((va % nbytes) != 0 || (bank == 2 && nbytes != 4)) code = 2'b10;
        else                                                    code = 2'b00;
        if (code != 2'b00) begin
            lat = 1; ens = 0; wes = 0;
            return;
        end
        lane = int'(va % 4);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        old  = refMem[bank][idx];
        if (!write) begin
            val = (old >> (8 * lane)) & mask;
            if (sgn && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
            rdata = val;
            lat = 3; ens = 1; wes = 0;
        end else begin
            newWord = (old & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
            lat = (nbytes == 4) ? 2 : 4;
            ens = (nbytes == 4) ? 1 : 2;
            wes = 1;
        end
    endfunction

    // driver tasks
    task automatic pokeWord(input int bank, input int idx, input logic [31:0] val);
        refMem[bank][idx] = val;
        @(negedge clk);
        pokeBank = bank; pokeIdx = idx; pokeVal = val; pokeEn = 1'b1;
        @(posedge clk);
        #1 pokeEn = 1'b0;
    endtask

    task automatic doTxn(input logic write, input logic [1:0] size, input logic sgn,
                         input logic [31:0] va, input logic [31:0] wd,
                         output logic [31:0] obsRdata, output logic [1:0] obsCode,
                         output int obsLat);
        logic [1:0]  eCode;
        int          eBank, eIdx, eLat, eEn, eWe, en0, we0, waitN;
        logic [31:0] eRdata, eWord;
        bit          got;
        model(write, size, sgn, va, wd, eCode, eBank, eIdx, eRdata, eWord, eLat, eEn, eWe);
        @(negedge clk);
        waitN = 0;
        while (!req_ready && waitN < 10) begin @(negedge clk); waitN++; end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_write = write; req_size = size; req_signed = sgn;
        req_addr = va; req_wdata = wd; req_valid = 1'b1;
        en0 = enCount; we0 = weCount;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        obsLat = 0; got = 1'b0;
        while (!got && obsLat < 10) begin
            @(negedge clk);
            obsLat++;
            if (resp_valid) got = 1'b1;
        end
        obsRdata = resp_rdata; obsCode = resp_code;
        check("latency", 32'(obsLat), 32'(eLat));
        check("resp_code", 32'(resp_code), 32'(eCode));
        check("resp_err", 32'(resp_err), 32'(eCode != 2'b00));
        check("resp_rdata", resp_rdata, eRdata);
        check("mem_en_cycles", 32'(enCount - en0), 32'(eEn));
        check("mem_we_cycles", 32'(weCount - we0), 32'(eWe));
        if (eCode == 2'b00) begin
            check("mem_bank", 32'(lastBank), 32'(eBank));
            check("mem_addr", 32'(lastAddr), 32'(eIdx));
            if (write) refMem[eBank][eIdx] = eWord;
            check("ram_word", ram[eBank][eIdx], refMem[eBank][eIdx]);
        end
    endtask

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // main sequence
    initial begin
        logic [31:0] r;
        logic [1:0]  c;
        int          l, b, x, we0;
        logic [31:0] va;
        logic [1:0]  sz;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_code", 32'(resp_code), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_bank", 32'(mem_bank), 32'd0);
        rst_n = 1'b1;

        // lw from data segment
        pokeWord(0, 2, 32'hDEAD_BEEF);
        doTxn(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, r, c, l);
        check("lw_rdata", r, 32'hDEAD_BEEF);
        check("lw_latency", 32'(l), 32'd3);

        // lb / lbu of the top byte
        pokeWord(0, 0, 32'h80FF_0000);
        doTxn(1'b0, 2'b00, 1'b1, 32'h1001_0003, 32'h0, r, c, l);
        check("lb_rdata", r, 32'hFFFF_FF80);
        doTxn(1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'h0, r, c, l);
        check("lbu_rdata", r, 32'h0000_0080);

        // sh into the top word of the stack segment
        pokeWord(1, 'h3FC, 32'h1122_3344);
        doTxn(1'b1, 2'b01, 1'b0, 32'hEFFF_FFF2, 32'h0000_ABCD, r, c, l);
        check("sh_word", ram[1]['h3FC], 32'hABCD_3344);
        check("sh_latency", 32'(l), 32'd4);

        // faults
        doTxn(1'b0, 2'b10, 1'b0, 32'h1001_1000, 32'h0, r, c, l);
        check("unmapped_code", 32'(c), 32'd1);
        doTxn(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, r, c, l);
        check("misaligned_code", 32'(c), 32'd2);
        doTxn(1'b0, 2'b11, 1'b0, 32'h1001_1001, 32'h0, r, c, l);
        check("illegal_code", 32'(c), 32'd3);
        doTxn(1'b0, 2'b10, 1'b0, 32'hEFFF_FFFC, 32'h0, r, c, l);
        check("stack_top_ok", 32'(c), 32'd0);
        doTxn(1'b0, 2'b10, 1'b0, 32'hF000_0000, 32'h0, r, c, l);
        check("stack_end_unmapped", 32'(c), 32'd1);

        // MMIO: sub-word rejected, word store reaches bank 2
        doTxn(1'b1, 2'b00, 1'b0, 32'hFFFF_0004, 32'h5, r, c, l);
        check("mmio_sb_code", 32'(c), 32'd2);
        doTxn(1'b1, 2'b10, 1'b0, 32'hFFFF_0004, 32'h5, r, c, l);
        check("mmio_sw_word", ram[2][1], 32'h5);
        check("sw_latency", 32'(l), 32'd2);

        // reset during RD_WAIT of a sub-word store
        pokeWord(0, 4, 32'h0102_0304);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h1001_0011; req_wdata = 32'h77; req_valid = 1'b1;
        we0 = weCount;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rmw_in_rd_wait", 32'(dbgState), 32'(ST_RD_WAIT));
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(dbgState), 32'(ST_IDLE));
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_write", 32'(weCount - we0), 32'd0);
        check("rst_mid_ram", ram[0][4], 32'h0102_0304);
        check("rst_mid_ready_after", 32'(req_ready), 32'd1);

        // randomized requests
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: va = 32'(M_DATA_BASE)  + $urandom_range(0, 4100);
                4, 5, 6:    va = 32'(M_STACK_BASE) + $urandom_range(0, 4100);
                7, 8:       va = 32'(M_MMIO_BASE)  + $urandom_range(0, 70);
                default:    va = $urandom;
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (regionOf(va, b, x) && $urandom_range(0, 1) == 1) pokeWord(b, x, $urandom);
            doTxn(1'($urandom), sz, 1'($urandom), va, $urandom, r, c, l);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
